// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
// Optional build macro: CPU_HALT_EN adds the S_HALT state for the 111_00 encoding.
package cpu_pkg;

   // Controller states (5-bit so the debug port can expose them directly)
   typedef enum logic [4:0] {
      S_RST   = 5'd0,
      S_IF1   = 5'd1,
      S_IF2   = 5'd2,
      S_UPC   = 5'd3,
      S_DEC   = 5'd4,
      S_IMM   = 5'd5,
      S_GET_A = 5'd6,
      S_GET_B = 5'd7,
      S_ALU   = 5'd8,
      S_WRB   = 5'd9,
      S_CMP   = 5'd10,
      S_ADDR  = 5'd11,
      S_LDA   = 5'd12,
      S_RD1   = 5'd13,
      S_RD2   = 5'd14,
      S_GET_D = 5'd15,
      S_STC   = 5'd16,
      S_STW   = 5'd17
`ifdef CPU_HALT_EN
      , S_HALT = 5'd18
`endif
   } state_t;

   // Opcode field instr[15:13]
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b111;

   // Op field instr[12:11]
   localparam logic [1:0] OP_MOVI = 2'b10;
   localparam logic [1:0] OP_MOV  = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_MVN  = 2'b11;
   localparam logic [1:0] OP_MEM  = 2'b00;
   localparam logic [1:0] OP_HALT = 2'b00;

   // RAM commands
   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   // One-hot register and write-back source selects
   localparam logic [2:0] NSEL_NONE  = 3'b000;
   localparam logic [2:0] NSEL_RN    = 3'b001;
   localparam logic [2:0] NSEL_RD    = 3'b010;
   localparam logic [2:0] NSEL_RM    = 3'b100;
   localparam logic [3:0] VSEL_NONE  = 4'b0000;
   localparam logic [3:0] VSEL_C     = 4'b0001;
   localparam logic [3:0] VSEL_PC    = 4'b0010;
   localparam logic [3:0] VSEL_IMM   = 4'b0100;
   localparam logic [3:0] VSEL_MDATA = 4'b1000;

   // Instruction class flags, one-hot
   typedef struct packed {
      logic movi;
      logic mov;
      logic alu;
      logic cmp;
      logic mvn;
      logic ldr;
      logic str;
      logic halt;
      logic bad;
   } class_t;

   // Full set of control strobes driven by the controller
   typedef struct packed {
      logic       load_ir;
      logic       load_pc;
      logic       reset_pc;
      logic       addr_sel;
      logic       load_addr;
      logic [1:0] mem_cmd;
      logic [2:0] nsel;
      logic [3:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       write;
      logic       halted;
   } ctrl_t;

   // Strobes for a given state; zero_a selects asel in S_ALU (MOV/MVN pass B only)
   function automatic ctrl_t state_ctrl(input state_t s, input logic zero_a);
      ctrl_t c;
      c         = '0;
      c.mem_cmd = MEM_NONE;
      c.nsel    = NSEL_NONE;
      c.vsel    = VSEL_NONE;
      case (s)
         S_RST:   begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
         S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
         S_IF2:   begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
         S_UPC:   c.load_pc = 1'b1;
         S_IMM:   begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1; end
         S_GET_A: begin c.nsel = NSEL_RN; c.loada = 1'b1; end
         S_GET_B: begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
         S_ALU:   begin c.loadc = 1'b1; c.asel = zero_a; end
         S_WRB:   begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
         S_CMP:   c.loads = 1'b1;
         S_ADDR:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
         S_LDA:   c.load_addr = 1'b1;
         S_RD1:   c.mem_cmd = MEM_READ;
         S_RD2:   begin
            c.mem_cmd = MEM_READ;
            c.nsel    = NSEL_RD;
            c.vsel    = VSEL_MDATA;
            c.write   = 1'b1;
         end
         S_GET_D: begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
         S_STC:   begin c.asel = 1'b1; c.loadc = 1'b1; end
         S_STW:   c.mem_cmd = MEM_WRITE;
`ifdef CPU_HALT_EN
         S_HALT:  c.halted = 1'b1;
`endif
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational decode of {opcode, op} into one-hot instruction class flags.
// Optional build macro: CPU_HALT_EN (without it 111_00 decodes as bad).
module instr_class
   import cpu_pkg::*;
(
   input  logic [2:0] i_opcode,
   input  logic [1:0] i_op,
   output logic       o_is_movi,
   output logic       o_is_mov,
   output logic       o_is_alu,
   output logic       o_is_cmp,
   output logic       o_is_mvn,
   output logic       o_is_ldr,
   output logic       o_is_str,
   output logic       o_is_halt,
   output logic       o_is_bad
);

   assign o_is_movi = (i_opcode == OPC_MOV) && (i_op == OP_MOVI);
   assign o_is_mov  = (i_opcode == OPC_MOV) && (i_op == OP_MOV);
   assign o_is_mvn  = (i_opcode == OPC_ALU) && (i_op == OP_MVN);
   assign o_is_cmp  = (i_opcode == OPC_ALU) && (i_op == OP_CMP);
   assign o_is_alu  = (i_opcode == OPC_ALU) && ((i_op == OP_ADD) || (i_op == OP_AND));
   assign o_is_ldr  = (i_opcode == OPC_LDR) && (i_op == OP_MEM);
   assign o_is_str  = (i_opcode == OPC_STR) && (i_op == OP_MEM);
`ifdef CPU_HALT_EN
   assign o_is_halt = (i_opcode == OPC_HALT) && (i_op == OP_HALT);
`else
   assign o_is_halt = 1'b0;
`endif
   // Anything not recognised above runs as a NOP
   assign o_is_bad  = ~(o_is_movi | o_is_mov | o_is_mvn | o_is_cmp | o_is_alu |
                        o_is_ldr | o_is_str | o_is_halt);

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control unit: fetch, decode and per-instruction strobe sequencing.
// Outputs are registered and decoded from the state being entered, so they are
// glitch-free Moore strobes aligned with the state register.
// Optional build macro: CPU_HALT_EN enables the S_HALT state for 111_00.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int MEM_CMD_W = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          instr,
   output logic                 load_ir,
   output logic                 load_pc,
   output logic                 reset_pc,
   output logic                 addr_sel,
   output logic                 load_addr,
   output logic [MEM_CMD_W-1:0] mem_cmd,
   output logic [2:0]           nsel,
   output logic [3:0]           vsel,
   output logic                 loada,
   output logic                 loadb,
   output logic                 loadc,
   output logic                 loads,
   output logic                 asel,
   output logic                 bsel,
   output logic                 write,
   output logic                 halted,
   output logic [4:0]           state
);

   state_t r_state;
   state_t w_next;
   ctrl_t  r_ctrl;
   class_t w_cls;
   logic   w_is_movi, w_is_mov, w_is_alu, w_is_cmp, w_is_mvn;
   logic   w_is_ldr, w_is_str, w_is_halt, w_is_bad;
   logic   w_unused_instr;

   // Operand fields are consumed by the datapath, not by the controller
   assign w_unused_instr = ^instr[10:0];

   instr_class u_instr_class (
      .i_opcode  (instr[15:13]),
      .i_op      (instr[12:11]),
      .o_is_movi (w_is_movi),
      .o_is_mov  (w_is_mov),
      .o_is_alu  (w_is_alu),
      .o_is_cmp  (w_is_cmp),
      .o_is_mvn  (w_is_mvn),
      .o_is_ldr  (w_is_ldr),
      .o_is_str  (w_is_str),
      .o_is_halt (w_is_halt),
      .o_is_bad  (w_is_bad)
   );

   assign w_cls = '{movi: w_is_movi, mov: w_is_mov, alu: w_is_alu, cmp: w_is_cmp,
                    mvn: w_is_mvn, ldr: w_is_ldr, str: w_is_str, halt: w_is_halt,
                    bad: w_is_bad};

   // Successor state for a non-reset cycle
   function automatic state_t next_state(input state_t s, input class_t c);
      state_t n;
      n = S_RST;
      case (s)
         S_RST:   n = S_IF1;
         S_IF1:   n = S_IF2;
         S_IF2:   n = S_UPC;
         S_UPC:   n = S_DEC;
         S_DEC: begin
            if (c.movi)                         n = S_IMM;
            else if (c.mov || c.mvn)            n = S_GET_B;
            else if (c.alu || c.cmp || c.ldr || c.str) n = S_GET_A;
`ifdef CPU_HALT_EN
            else if (c.halt)                    n = S_HALT;
            else if (c.bad)                     n = S_IF1;
`else
            else if (c.bad || c.halt)           n = S_IF1;
`endif
            else                                n = S_IF1;
         end
         S_IMM:   n = S_IF1;
         S_GET_A: n = (c.ldr || c.str) ? S_ADDR : S_GET_B;
         S_GET_B: n = c.cmp ? S_CMP : S_ALU;
         S_ALU:   n = S_WRB;
         S_WRB:   n = S_IF1;
         S_CMP:   n = S_IF1;
         S_ADDR:  n = S_LDA;
         S_LDA:   n = c.ldr ? S_RD1 : S_GET_D;
         S_RD1:   n = S_RD2;
         S_RD2:   n = S_IF1;
         S_GET_D: n = S_STC;
         S_STC:   n = S_STW;
         S_STW:   n = S_IF1;
`ifdef CPU_HALT_EN
         S_HALT:  n = S_HALT;
`endif
         default: n = S_RST;
      endcase
      return n;
   endfunction

   assign w_next = next_state(r_state, w_cls);

   // State register plus registered strobes for the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RST;
         r_ctrl  <= state_ctrl(S_RST, 1'b0);
      end else begin
         r_state <= w_next;
         r_ctrl  <= state_ctrl(w_next, w_is_mov | w_is_mvn);
      end
   end

   assign load_ir   = r_ctrl.load_ir;
   assign load_pc   = r_ctrl.load_pc;
   assign reset_pc  = r_ctrl.reset_pc;
   assign addr_sel  = r_ctrl.addr_sel;
   assign load_addr = r_ctrl.load_addr;
   assign mem_cmd   = MEM_CMD_W'(r_ctrl.mem_cmd);
   assign nsel      = r_ctrl.nsel;
   assign vsel      = r_ctrl.vsel;
   assign loada     = r_ctrl.loada;
   assign loadb     = r_ctrl.loadb;
   assign loadc     = r_ctrl.loadc;
   assign loads     = r_ctrl.loads;
   assign asel      = r_ctrl.asel;
   assign bsel      = r_ctrl.bsel;
   assign write     = r_ctrl.write;
   assign state     = r_state;
`ifdef CPU_HALT_EN
   assign halted    = r_ctrl.halted;
`else
   assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed fetch/reset/halt cases plus
// randomized instructions checked against a per-instruction behaviour summary.
module tb_cpu_controller;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] instr = 16'h0000;
   logic        load_ir, load_pc, reset_pc, addr_sel, load_addr;
   logic [1:0]  mem_cmd;
   logic [2:0]  nsel;
   logic [3:0]  vsel;
   logic        loada, loadb, loadc, loads, asel, bsel, write, halted;
   logic [4:0]  st;

   int n_cmp = 0;
   int n_err = 0;

   cpu_controller #(.MEM_CMD_W(2)) dut (
      .clk(clk), .reset(reset), .instr(instr),
      .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
      .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
      .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
      .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
      .write(write), .halted(halted), .state(st)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   // Per-instruction behaviour summary: cycle count and how often each strobe fires
   typedef struct packed {
      logic [7:0] cyc;
      logic [7:0] wr;
      logic [7:0] loada;
      logic [7:0] loadb;
      logic [7:0] loadc;
      logic [7:0] loads;
      logic [7:0] rd;
      logic [7:0] wcmd;
      logic [7:0] ldaddr;
      logic [7:0] bsel;
      logic [7:0] asel;
      logic [7:0] ldir;
      logic [7:0] ldpc;
      logic [7:0] fetch;
      logic [7:0] halt;
      logic [2:0] wr_nsel;
      logic [3:0] wr_vsel;
      logic [2:0] lda_nsel;
      logic [2:0] ldb_nsel;
   } tally_t;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic at_if1();
      return (mem_cmd == 2'b01) && addr_sel && !load_ir;
   endfunction

   // Expected summary of one instruction, from the per-instruction step lists
   function automatic tally_t expect_of(input logic [15:0] ins);
      tally_t e;
      e = '0;
      e.ldir = 1; e.ldpc = 1; e.fetch = 2;
      case (ins[15:11])
         5'b11010: begin e.cyc = 5; e.wr = 1; e.wr_nsel = 3'b001; e.wr_vsel = 4'b0100; end
         5'b11000, 5'b10111: begin
            e.cyc = 7; e.loadb = 1; e.ldb_nsel = 3'b100; e.loadc = 1; e.asel = 1;
            e.wr = 1; e.wr_nsel = 3'b010; e.wr_vsel = 4'b0001;
         end
         5'b10100, 5'b10110: begin
            e.cyc = 8; e.loada = 1; e.lda_nsel = 3'b001; e.loadb = 1; e.ldb_nsel = 3'b100;
            e.loadc = 1; e.wr = 1; e.wr_nsel = 3'b010; e.wr_vsel = 4'b0001;
         end
         5'b10101: begin
            e.cyc = 7; e.loada = 1; e.lda_nsel = 3'b001; e.loadb = 1; e.ldb_nsel = 3'b100;
            e.loads = 1;
         end
         5'b01100: begin
            e.cyc = 9; e.loada = 1; e.lda_nsel = 3'b001; e.loadc = 1; e.bsel = 1;
            e.ldaddr = 1; e.rd = 2; e.wr = 1; e.wr_nsel = 3'b010; e.wr_vsel = 4'b1000;
         end
         5'b10000: begin
            e.cyc = 10; e.loada = 1; e.lda_nsel = 3'b001; e.loadc = 2; e.bsel = 1;
            e.ldaddr = 1; e.loadb = 1; e.ldb_nsel = 3'b010; e.asel = 1; e.wcmd = 1;
         end
         default: e.cyc = 4;
      endcase
      return e;
   endfunction

   function automatic logic onehot0(input logic [3:0] v);
      return (v & (v - 4'd1)) == 4'd0;
   endfunction

   // Call at the negedge of an S_IF1 cycle; returns at the next S_IF1 cycle
   task automatic run_instr(input logic [15:0] ins, input string tag);
      tally_t o, e;
      int     viol;
      int     k;
      o = '0; viol = 0; k = 0;
      e = expect_of(ins);
      instr = ins;
      do begin
         o.cyc++;
         if (write) begin o.wr++; o.wr_nsel = nsel; o.wr_vsel = vsel; end
         if (loada) begin o.loada++; o.lda_nsel = nsel; end
         if (loadb) begin o.loadb++; o.ldb_nsel = nsel; end
         if (loadc) o.loadc++;
         if (loads) o.loads++;
         if (mem_cmd == 2'b01 && !addr_sel) o.rd++;
         if (mem_cmd == 2'b01 && addr_sel) o.fetch++;
         if (mem_cmd == 2'b10 && !addr_sel) o.wcmd++;
         if (load_addr) o.ldaddr++;
         if (bsel) o.bsel++;
         if (asel) o.asel++;
         if (load_ir) o.ldir++;
         if (load_pc) o.ldpc++;
         if (halted) o.halt++;
         if ((write && mem_cmd == 2'b10) || !onehot0({1'b0, nsel}) || !onehot0(vsel) || reset_pc)
            viol++;
         @(negedge clk);
         k++;
      end while (!at_if1() && k < 40);
      check_eq($sformatf("%s back_to_if1", tag), {31'd0, at_if1()}, 32'd1);
      check_eq($sformatf("%s cycles", tag), {24'd0, o.cyc}, {24'd0, e.cyc});
      check_eq($sformatf("%s writes", tag), {24'd0, o.wr}, {24'd0, e.wr});
      check_eq($sformatf("%s wr_sel", tag), {25'd0, o.wr_nsel, o.wr_vsel}, {25'd0, e.wr_nsel, e.wr_vsel});
      check_eq($sformatf("%s loada", tag), {21'd0, o.loada, o.lda_nsel}, {21'd0, e.loada, e.lda_nsel});
      check_eq($sformatf("%s loadb", tag), {21'd0, o.loadb, o.ldb_nsel}, {21'd0, e.loadb, e.ldb_nsel});
      check_eq($sformatf("%s loadc_loads", tag), {16'd0, o.loadc, o.loads}, {16'd0, e.loadc, e.loads});
      check_eq($sformatf("%s mem", tag), {8'd0, o.rd, o.wcmd, o.fetch}, {8'd0, e.rd, e.wcmd, e.fetch});
      check_eq($sformatf("%s ldaddr_bsel_asel", tag), {8'd0, o.ldaddr, o.bsel, o.asel},
               {8'd0, e.ldaddr, e.bsel, e.asel});
      check_eq($sformatf("%s ldir_ldpc_halt", tag), {8'd0, o.ldir, o.ldpc, o.halt},
               {8'd0, e.ldir, e.ldpc, e.halt});
      check_eq($sformatf("%s invariants", tag), viol, 0);
      $display("instr %s 0x%04h: %0d cycles, %0d writes", tag, ins, o.cyc, o.wr);
   endtask

   task automatic wait_if1(input string tag);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!at_if1() && k < 10);
      check_eq($sformatf("%s reach_if1", tag), {31'd0, at_if1()}, 32'd1);
   endtask

   function automatic logic is_valid_key(input logic [4:0] key);
      return key == 5'b11010 || key == 5'b11000 || key == 5'b10111 || key == 5'b10100 ||
             key == 5'b10110 || key == 5'b10101 || key == 5'b01100 || key == 5'b10000;
   endfunction

   initial begin
      logic [4:0]  keys [8];
      logic [4:0]  key;
      logic [15:0] ins;
      logic        found;
      logic        wr_seen;
      int          cnt;
      keys = '{5'b11010, 5'b11000, 5'b10111, 5'b10100, 5'b10110, 5'b10101, 5'b01100, 5'b10000};

      // Reset held three cycles
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst.reset_pc_load_pc", {30'd0, reset_pc, load_pc}, 32'd3);
         check_eq("rst.write_mem", {29'd0, write, mem_cmd}, 32'd0);
         check_eq("rst.state", {27'd0, st}, {27'd0, S_RST});
         $display("reset cycle %0d: reset_pc=%0b load_pc=%0b", i, reset_pc, load_pc);
      end
      reset = 1'b0;
      @(negedge clk);
      check_eq("if1.addr_sel", {31'd0, addr_sel}, 32'd1);
      check_eq("if1.mem_cmd", {30'd0, mem_cmd}, 32'd1);
      check_eq("if1.load_ir_pc", {30'd0, load_ir, load_pc}, 32'd0);

      // Directed instructions
      run_instr(16'hD007, "movi");
      run_instr(16'hA140, "add");
      run_instr(16'hA900, "cmp");
      run_instr(16'h6061, "ldr");
      run_instr(16'h8062, "str");
      run_instr(16'hB860, "mvn");
      run_instr(16'hC041, "mov");
      run_instr(16'hB140, "and");

`ifdef CPU_HALT_EN
      // HALT parks until reset
      instr = 16'hE000;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         found = halted;
      end
      check_eq("halt.entered", {31'd0, found}, 32'd1);
      cnt = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (halted && !write && mem_cmd == 2'b00 && !load_pc && !load_ir) cnt++;
      end
      check_eq("halt.persist", cnt, 25);
      $display("halt held %0d cycles", cnt);
      reset = 1'b1;
      @(negedge clk);
      check_eq("halt.reset_state", {27'd0, st}, {27'd0, S_RST});
      check_eq("halt.cleared", {30'd0, halted, reset_pc}, 32'd1);
      reset = 1'b0;
      wait_if1("halt.exit");
`else
      run_instr(16'hE000, "halt_as_nop");
`endif

      // Reset asserted in S_RD1 must suppress the S_RD2 write
      instr = 16'h6061;
      found = 1'b0; wr_seen = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         @(negedge clk);
         wr_seen |= write;
         found = (mem_cmd == 2'b01) && !addr_sel;
      end
      check_eq("rstmid.reached_rd1", {31'd0, found}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("rstmid.no_write", {30'd0, write, wr_seen}, 32'd0);
      check_eq("rstmid.reset_pc", {31'd0, reset_pc}, 32'd1);
      check_eq("rstmid.state", {27'd0, st}, {27'd0, S_RST});
      $display("reset in RD1: write=%0b state=%0d", write, st);
      @(negedge clk);
      check_eq("rstmid.hold", {30'd0, reset_pc, write}, 32'd2);
      reset = 1'b0;
      wait_if1("rstmid.exit");

      // Randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 8) begin
            key = keys[r];
         end else begin
            do key = 5'($urandom); while (is_valid_key(key) || key == 5'b11100);
         end
         ins = {key, 11'($urandom)};
         run_instr(ins, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
